chicken_judge: RTL and testbench
================================

Name: chicken_judge

Overview:
- Game datapath directly downstream of the Chicken Cha-Cha-Cha control FSM.
- Consumes the FSM state code M, player count N, card key and strobes A/B.
- Tracks the current player, each player's track position and step count, judges each flipped card against the next tile, and returns the registered go/win verdicts the FSM samples.
- Also drives player/position status to the display logic.

Parameters:
- TRACK_LEN, 16, number of tiles on the circular track; must be a power of 2, at least 4.
- IMG_NUM, 8, number of distinct images; cards are key 1..IMG_NUM.
- WIN_STEPS, 16, successful moves a player needs to win (1..255).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- M  in  3  control FSM state code
- N  in  2  player count from FSM; 2'b00 means 4 players
- key  in  4  card selection, 0 = none
- A  in  1  FSM waiting-for-card flag (status only, not used for gating)
- B  in  1  FSM move strobe, high while M=3'b110
- go  out  1  registered: last flipped card matched the next tile
- win  out  1  registered: that match completes WIN_STEPS
- cur_player  out  2  index of the player whose turn it is
- pos_bus  out  4*log2(TRACK_LEN)  positions, player p in slice p
- winner_valid  out  1  high while M=3'b111; cur_player is the winner

Behaviour:
- Reset (rst=0, async): go=0, win=0, cur_player=0, winner_valid=0, all pos=0, all step counters=0, n_players=0.
  - Effective immediately, even mid-turn.
  - State recovers only via a new M=3'b010 init.
- Images:
  - tile_img(t) = (3*t+1) mod IMG_NUM.
  - card_img(k) = k-1 for 1<=k<=IMG_NUM.
  - Keys above IMG_NUM never match.
- M=3'b000 (idle): hold all registers; go=win=0.
- M=3'b010 (init, one cycle):
  - n_players <= (N==0) ? 4 : N.
  - pos[p] <= p*TRACK_LEN/4; steps[p] <= 0; cur_player <= 0; go <= 0; win <= 0.
- M=3'b011 (await card), on an edge where key!=0:
  - nxt = (pos[cur]+1) mod TRACK_LEN.
  - go <= (key<=IMG_NUM) && card_img(key)==tile_img(nxt).
  - win <= go_value && (steps[cur]+1 == WIN_STEPS).
  - This is the same edge on which the FSM enters 3'b100, so go is valid the whole 3'b100 cycle: latency 1.
  - key==0: go and win hold.
- M=3'b101 (miss):
  - cur_player <= (cur_player+1 == n_players) ? 0 : cur_player+1.
  - go <= 0.
- M=3'b110 (hit, B=1):
  - pos[cur] <= nxt, wrapping at TRACK_LEN.
  - steps[cur] <= steps[cur]+1, saturating at WIN_STEPS.
  - cur_player unchanged: the same player flips again.
  - win stays valid through this cycle; go and win clear on the following edge unless M=3'b111.
- M=3'b111: winner_valid=1; cur_player, pos and win frozen.
- Other codes (3'b001, 3'b100): hold all registers.
- Occupancy: players may share a tile; no blocking.
- Simultaneous events: key changes during 3'b100/3'b101/3'b110 are ignored; only 3'b011 samples key.
- Unused players (p >= n_players): positions and steps hold init values and are never selected.

Decomposition:
- Shared package chicken_pkg:
  - State codes ST_IDLE=3'b000, ST_SETUP=3'b001, ST_INIT=3'b010, ST_WAIT=3'b011, ST_JUDGE=3'b100, ST_MISS=3'b101, ST_MOVE=3'b110, ST_DONE=3'b111.
  - Defaults for TRACK_LEN, IMG_NUM and WIN_STEPS.
  - This package is also adopted by the control FSM.
- One sub-module, chicken_image_rom: combinational tile_img/card_img lookup plus the key range check, outputting match.

Test Plan:
- Init, N=2'b00: after M=3'b010, n_players=4, pos_bus = {12,8,4,0}, cur_player=0, go=0.
- Hit, player 0 at pos 0: next tile 1 has image 4; key=5 in M=3'b011 → go=1 next cycle, win=0; after M=3'b110, pos[0]=1 and steps[0]=1.
- Miss rotation, N=2'b11: key=1 (image 0 vs 4) → go=0; three miss turns give cur_player 0→1→2→0.
- Out-of-range key=4'hF in M=3'b011 → go=0, and the turn passes on 3'b101.
- Win, WIN_STEPS=2, player 0: two consecutive hits (key=5, then tile 2 image 7 → key=8) → second judge gives go=1, win=1; in M=3'b111, winner_valid=1 and cur_player=0.
- Reset mid-turn: rst=0 asserted while M=3'b110 → go, win, cur_player and pos_bus are 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/chicken_pkg.sv
// Shared definitions for the Chicken Cha-Cha-Cha game: control state codes
// and default game dimensions, used by both the control FSM and the judge.
package chicken_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_SETUP = 3'b001,
    ST_INIT  = 3'b010,
    ST_WAIT  = 3'b011,
    ST_JUDGE = 3'b100,
    ST_MISS  = 3'b101,
    ST_MOVE  = 3'b110,
    ST_DONE  = 3'b111
  } chicken_state_t;

  localparam int TRACK_LEN_DEF = 16;
  localparam int IMG_NUM_DEF   = 8;
  localparam int WIN_STEPS_DEF = 16;
  localparam int MAX_PLAYERS   = 4;

endpackage

// File: rtl/chicken_judge_if.sv
// Control-FSM <-> judge bundle. M is the FSM state code, key is sampled only
// while M is ST_WAIT, B qualifies the ST_MOVE update, and go/win are
// registered verdicts that stay stable through ST_JUDGE and ST_MOVE.
interface chicken_judge_if #(
  parameter int PW = 4
);
  logic [2:0]      M;
  logic [1:0]      N;
  logic [3:0]      key;
  logic            A;
  logic            B;
  logic            go;
  logic            win;
  logic [1:0]      cur_player;
  logic [4*PW-1:0] pos_bus;
  logic            winner_valid;

  modport master (
    output M, N, key, A, B,
    input  go, win, cur_player, pos_bus, winner_valid
  );

  modport slave (
    input  M, N, key, A, B,
    output go, win, cur_player, pos_bus, winner_valid
  );
endinterface

// File: rtl/chicken_image_rom.sv
// Combinational image lookup: compares the flipped card's image with the
// image printed on a track tile. Keys outside 1..IMG_NUM never match.
module chicken_image_rom #(
  parameter int TRACK_LEN = chicken_pkg::TRACK_LEN_DEF,
  parameter int IMG_NUM   = chicken_pkg::IMG_NUM_DEF,
  parameter int PW        = $clog2(TRACK_LEN)
) (
  input  logic [PW-1:0] tile,
  input  logic [3:0]    key,
  output logic          match
);

  int unsigned tile_img;
  int unsigned card_img;
  logic        in_range;

  always_comb begin
    tile_img = ((32'(tile) * 3) + 1) % IMG_NUM;
    card_img = 32'(key) - 1;
    in_range = (key != 4'd0) && (32'(key) <= IMG_NUM);
    match    = in_range && (card_img == tile_img);
  end

endmodule

// File: rtl/chicken_judge.sv
// Game datapath beside the control FSM: tracks turn, positions and step
// counts, and registers the go/win verdict for each flipped card.
module chicken_judge
  import chicken_pkg::*;
#(
  parameter int TRACK_LEN = TRACK_LEN_DEF,
  parameter int IMG_NUM   = IMG_NUM_DEF,
  parameter int WIN_STEPS = WIN_STEPS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  chicken_judge_if.slave  bus
);

  localparam int PW = $clog2(TRACK_LEN);

  chicken_state_t st;
  logic [PW-1:0]  pos_q   [MAX_PLAYERS];
  logic [7:0]     steps_q [MAX_PLAYERS];
  logic [1:0]     cur_q;
  logic [2:0]     n_players_q;
  logic           go_q;
  logic           win_q;

  logic [PW-1:0]  nxt;
  logic           match;
  logic           last_step;
  logic [1:0]     next_player;

  assign st = chicken_state_t'(bus.M);

  // Tile ahead of the current player; the power-of-2 width makes it wrap.
  assign nxt       = pos_q[cur_q] + PW'(1);
  assign last_step = ({1'b0, steps_q[cur_q]} + 9'd1) == 9'(WIN_STEPS);
  assign next_player = (({1'b0, cur_q} + 3'd1) == n_players_q) ? 2'd0 : cur_q + 2'd1;

  chicken_image_rom #(
    .TRACK_LEN (TRACK_LEN),
    .IMG_NUM   (IMG_NUM),
    .PW        (PW)
  ) u_rom (
    .tile  (nxt),
    .key   (bus.key),
    .match (match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go_q        <= 1'b0;
      win_q       <= 1'b0;
      cur_q       <= 2'd0;
      n_players_q <= 3'd0;
      for (int p = 0; p < MAX_PLAYERS; p++) begin
        pos_q[p]   <= '0;
        steps_q[p] <= 8'd0;
      end
    end else begin
      case (st)
        ST_IDLE: begin
          go_q  <= 1'b0;
          win_q <= 1'b0;
        end
        ST_INIT: begin
          n_players_q <= (bus.N == 2'd0) ? 3'd4 : {1'b0, bus.N};
          cur_q       <= 2'd0;
          go_q        <= 1'b0;
          win_q       <= 1'b0;
          for (int p = 0; p < MAX_PLAYERS; p++) begin
            pos_q[p]   <= PW'(p * TRACK_LEN / 4);
            steps_q[p] <= 8'd0;
          end
        end
        ST_WAIT: begin
          if (bus.key != 4'd0) begin
            go_q  <= match;
            win_q <= match && last_step;
          end
        end
        ST_MISS: begin
          cur_q <= next_player;
          go_q  <= 1'b0;
        end
        ST_MOVE: begin
          if (bus.B) begin
            pos_q[cur_q] <= nxt;
            if (steps_q[cur_q] < 8'(WIN_STEPS))
              steps_q[cur_q] <= steps_q[cur_q] + 8'd1;
            // A winning hit keeps go/win up into ST_DONE; otherwise go drops.
            go_q <= win_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.pos_bus = '0;
    for (int p = 0; p < MAX_PLAYERS; p++)
      bus.pos_bus[p*PW +: PW] = pos_q[p];
  end

  assign bus.go           = go_q;
  assign bus.win          = win_q;
  assign bus.cur_player   = cur_q;
  assign bus.winner_valid = (st == ST_DONE);

  // A is a status flag for display only.
  logic unused_a;
  assign unused_a = bus.A;

endmodule

// File: tb/tb_chicken_judge.sv
// Directed bench for chicken_judge with WIN_STEPS=2 so a win is reachable
// in two hits; expected values are hand-computed from the tile image table.
module tb_chicken_judge;
  import chicken_pkg::*;

  localparam int PW = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  chicken_judge_if #(.PW(PW)) bus ();

  chicken_judge #(
    .TRACK_LEN (16),
    .IMG_NUM   (8),
    .WIN_STEPS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of FSM outputs, then sample 1ns after the edge.
  task automatic cyc(input logic [2:0] m, input logic [1:0] n, input logic [3:0] k);
    bus.M   = m;
    bus.N   = n;
    bus.key = k;
    bus.A   = (m == ST_WAIT);
    bus.B   = (m == ST_MOVE);
    @(posedge clk);
    #1;
  endtask

  task automatic miss_turn(input logic [3:0] k, input logic [1:0] exp_cur, input string tag);
    cyc(ST_WAIT, 2'd3, k);
    check({tag, "_go"}, {15'd0, bus.go}, 16'd0);
    cyc(ST_JUDGE, 2'd3, 4'd5);
    cyc(ST_MISS, 2'd3, 4'd0);
    check({tag, "_cur"}, {14'd0, bus.cur_player}, {14'd0, exp_cur});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bus.M   = ST_IDLE;
    bus.N   = 2'd0;
    bus.key = 4'd0;
    bus.A   = 1'b0;
    bus.B   = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_go",  {15'd0, bus.go}, 16'd0);
    check("rst_win", {15'd0, bus.win}, 16'd0);
    check("rst_cur", {14'd0, bus.cur_player}, 16'd0);
    check("rst_pos", bus.pos_bus, 16'h0000);
    check("rst_wv",  {15'd0, bus.winner_valid}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(ST_IDLE, 2'd0, 4'd0);

    // Init with four players
    cyc(ST_INIT, 2'd0, 4'd0);
    check("init4_pos", bus.pos_bus, 16'hC840);
    check("init4_cur", {14'd0, bus.cur_player}, 16'd0);
    check("init4_go",  {15'd0, bus.go}, 16'd0);

    // Hit: tile 1 has image 4, key 5 shows image 4
    cyc(ST_WAIT, 2'd0, 4'd5);
    check("hit_go",  {15'd0, bus.go}, 16'd1);
    check("hit_win", {15'd0, bus.win}, 16'd0);
    cyc(ST_JUDGE, 2'd0, 4'd1);
    check("hit_judge_go", {15'd0, bus.go}, 16'd1);
    cyc(ST_MOVE, 2'd0, 4'd0);
    check("hit_pos", bus.pos_bus, 16'hC841);
    check("hit_cur", {14'd0, bus.cur_player}, 16'd0);
    check("hit_go_clr", {15'd0, bus.go}, 16'd0);

    // Out-of-range key never matches; turn passes on miss
    cyc(ST_WAIT, 2'd0, 4'hF);
    check("oor_go", {15'd0, bus.go}, 16'd0);
    cyc(ST_JUDGE, 2'd0, 4'd0);
    cyc(ST_MISS, 2'd0, 4'd0);
    check("oor_cur", {14'd0, bus.cur_player}, 16'd1);
    check("oor_pos", bus.pos_bus, 16'hC841);

    // Three players, three misses rotate 0->1->2->0
    cyc(ST_INIT, 2'd3, 4'd0);
    check("init3_pos", bus.pos_bus, 16'hC840);
    check("init3_cur", {14'd0, bus.cur_player}, 16'd0);
    miss_turn(4'd1, 2'd1, "miss_p0");
    miss_turn(4'd3, 2'd2, "miss_p1");
    miss_turn(4'd3, 2'd0, "miss_p2");

    // Win in two hits with two players
    cyc(ST_INIT, 2'd2, 4'd0);
    cyc(ST_WAIT, 2'd2, 4'd5);
    check("win1_go",  {15'd0, bus.go}, 16'd1);
    check("win1_win", {15'd0, bus.win}, 16'd0);
    cyc(ST_JUDGE, 2'd2, 4'd0);
    cyc(ST_MOVE, 2'd2, 4'd0);
    check("win1_pos", bus.pos_bus, 16'hC841);
    cyc(ST_WAIT, 2'd2, 4'd8);
    check("win2_go",  {15'd0, bus.go}, 16'd1);
    check("win2_win", {15'd0, bus.win}, 16'd1);
    cyc(ST_JUDGE, 2'd2, 4'd0);
    cyc(ST_MOVE, 2'd2, 4'd0);
    check("win2_pos", bus.pos_bus, 16'hC842);
    check("win2_move_win", {15'd0, bus.win}, 16'd1);
    bus.M = ST_DONE;
    bus.B = 1'b0;
    #1;
    check("done_wv", {15'd0, bus.winner_valid}, 16'd1);
    @(posedge clk); #1;
    check("done_cur", {14'd0, bus.cur_player}, 16'd0);
    check("done_win", {15'd0, bus.win}, 16'd1);
    check("done_pos", bus.pos_bus, 16'hC842);

    // Asynchronous reset in the middle of a move
    cyc(ST_INIT, 2'd0, 4'd0);
    cyc(ST_WAIT, 2'd0, 4'hF);
    cyc(ST_JUDGE, 2'd0, 4'd0);
    cyc(ST_MISS, 2'd0, 4'd0);
    cyc(ST_WAIT, 2'd0, 4'd1);
    check("pre_rst_go",  {15'd0, bus.go}, 16'd1);
    check("pre_rst_cur", {14'd0, bus.cur_player}, 16'd1);
    cyc(ST_JUDGE, 2'd0, 4'd0);
    bus.M = ST_MOVE;
    bus.B = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("arst_go",  {15'd0, bus.go}, 16'd0);
    check("arst_win", {15'd0, bus.win}, 16'd0);
    check("arst_cur", {14'd0, bus.cur_player}, 16'd0);
    check("arst_pos", bus.pos_bus, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(ST_IDLE, 2'd0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
